// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 codes, FSM states
// and the latched request record.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes and replicated write data, load
// byte/halfword selection with extension, and misaligned/illegal detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic        illegal;

  always_comb begin
    byte_sh = rdata_i >> {addr_lo_i, 3'b000};
    half_sh = rdata_i >> {addr_lo_i[1], 4'b0000};

    // Stores have no unsigned variants, so funct3[2] set on a store is illegal.
    illegal = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) || (we_i && funct3_i[2]);
    misaligned_o = illegal
                || ((funct3_i[1:0] == 2'b01) && addr_lo_i[0])
                || ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));

    wstrb_o = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;

    if (we_i) begin
      case (funct3_i)
        F3_SB: begin
          wstrb_o = 4'b0001 << addr_lo_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        F3_SH: begin
          wstrb_o = 4'b0011 << addr_lo_i;
          wdata_o = {2{wdata_i[15:0]}};
        end
        F3_SW: begin
          wstrb_o = 4'b1111;
          wdata_o = wdata_i;
        end
        default: ;
      endcase
    end else begin
      case (funct3_i)
        F3_LB:   rdata_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
        F3_LBU:  rdata_o = {24'h0, byte_sh[7:0]};
        F3_LH:   rdata_o = {{16{half_sh[15]}}, half_sh[15:0]};
        F3_LHU:  rdata_o = {16'h0, half_sh[15:0]};
        F3_LW:   rdata_o = rdata_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op at a time, runs a single valid/ready
// bus transaction with timeout, and returns a one-cycle completion pulse.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_timeout,
  output logic        busy
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  lsu_state_t      state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mis_q, mis_d;
  logic            to_q, to_d;

  logic            al_we;
  logic [2:0]      al_funct3;
  logic [1:0]      al_addr_lo;
  logic [31:0]     al_wdata_in;
  logic [3:0]      al_wstrb;
  logic [31:0]     al_wdata;
  logic [31:0]     al_rdata;
  logic            al_mis;

  // In IDLE the checker looks at the incoming request so an illegal access can
  // respond the very next cycle; afterwards it works from the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      al_we       = req_we;
      al_funct3   = req_funct3;
      al_addr_lo  = req_addr[1:0];
      al_wdata_in = req_wdata;
    end else begin
      al_we       = req_q.we;
      al_funct3   = req_q.funct3;
      al_addr_lo  = req_q.addr[1:0];
      al_wdata_in = req_q.wdata;
    end
  end

  lsu_align u_align (
    .we_i         (al_we),
    .funct3_i     (al_funct3),
    .addr_lo_i    (al_addr_lo),
    .wdata_i      (al_wdata_in),
    .rdata_i      (mem_rdata),
    .wstrb_o      (al_wstrb),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misaligned_o (al_mis)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    to_d    = to_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.we     = req_we;
          req_d.funct3 = req_funct3;
          req_d.addr   = req_addr;
          req_d.wdata  = req_wdata;
          cnt_d        = '0;
          rdata_d      = '0;
          mis_d        = al_mis;
          to_d         = 1'b0;
          state_d      = al_mis ? RESP : BUS;
        end
      end
      BUS: begin
        if (mem_ready) begin
          rdata_d = req_q.we ? 32'h0 : al_rdata;
          state_d = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntMax)) begin
          rdata_d = '0;
          to_d    = 1'b1;
          state_d = RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

  // Bus and response outputs are forced to zero outside their owning state.
  always_comb begin
    req_ready       = (state_q == IDLE);
    busy            = (state_q != IDLE);
    mem_valid       = (state_q == BUS);
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wstrb       = 4'b0000;
    mem_wdata       = '0;
    resp_valid      = (state_q == RESP);
    resp_rdata      = '0;
    resp_misaligned = 1'b0;
    resp_timeout    = 1'b0;
    if (state_q == BUS) begin
      mem_we    = req_q.we;
      mem_addr  = {req_q.addr[31:2], 2'b00};
      mem_wstrb = al_wstrb;
      mem_wdata = al_wdata;
    end
    if (state_q == RESP) begin
      resp_rdata      = rdata_q;
      resp_misaligned = mis_q;
      resp_timeout    = to_q;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: expected responses are queued when a request is
// issued and compared when resp_valid pulses; bus and timing checked inline.
module tb_lsu;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_timeout;
  logic        busy;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wstrb       (mem_wstrb),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_timeout    (resp_timeout),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        to;
  } resp_t;

  resp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic push_exp(input logic [31:0] rdata, input logic mis, input logic to);
    resp_t e;
    e.rdata = rdata;
    e.mis   = mis;
    e.to    = to;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every completion pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      resp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got rdata=%h mis=%b to=%b, none expected",
                 resp_rdata, resp_misaligned, resp_timeout);
      end else begin
        e = exp_q.pop_front();
        if ({resp_rdata, resp_misaligned, resp_timeout} !== {e.rdata, e.mis, e.to}) begin
          errors++;
          $display("FAIL resp_data: got rdata=%h mis=%b to=%b, want rdata=%h mis=%b to=%b",
                   resp_rdata, resp_misaligned, resp_timeout, e.rdata, e.mis, e.to);
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of cycle N+1.
  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, busy, mem_valid, mem_we, resp_valid, resp_misaligned, resp_timeout}
        !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 1000000", {req_ready, busy, mem_valid, mem_we,
               resp_valid, resp_misaligned, resp_timeout});
    end
    checks++;
    if ({mem_addr, mem_wstrb, mem_wdata, resp_rdata} !== 100'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h strb=%b wdata=%h rdata=%h want all 0",
               mem_addr, mem_wstrb, mem_wdata, resp_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stores();
    logic [2:0]  f3   [4] = '{3'b010, 3'b000, 3'b001, 3'b000};
    logic [31:0] addr [4] = '{32'h100, 32'h103, 32'h102, 32'h101};
    logic [31:0] wd   [4] = '{32'hDEADBEEF, 32'h000000A5, 32'h1234BEEF, 32'hFFFFFF3C};
    logic [31:0] xa   [4] = '{32'h100, 32'h100, 32'h100, 32'h100};
    logic [3:0]  xs   [4] = '{4'b1111, 4'b1000, 4'b1100, 4'b0010};
    logic [31:0] xd   [4] = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'hBEEFBEEF, 32'h3C3C3C3C};
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_exp(32'h0, 1'b0, 1'b0);
      drive_req(1'b1, f3[i], addr[i], wd[i]);
      checks++;
      if ({mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata, resp_valid}
          !== {1'b1, 1'b1, xa[i], xs[i], xd[i], 1'b0}) begin
        errors++;
        $display("FAIL store_bus[%0d]: got v=%b we=%b a=%h s=%b d=%h rv=%b want a=%h s=%b d=%h",
                 i, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata, resp_valid,
                 xa[i], xs[i], xd[i]);
      end
      @(negedge clk);
      checks++;
      if ({resp_valid, mem_valid} !== 2'b10) begin
        errors++;
        $display("FAIL store_latency[%0d]: got resp_valid=%b mem_valid=%b want 1 0",
                 i, resp_valid, mem_valid);
      end
      @(negedge clk);
      checks++;
      if ({req_ready, mem_valid, resp_valid, mem_addr} !== {3'b100, 32'h0}) begin
        errors++;
        $display("FAIL store_idle[%0d]: got rdy=%b v=%b rv=%b a=%h want 1 0 0 0",
                 i, req_ready, mem_valid, resp_valid, mem_addr);
      end
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3   [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010, 3'b001, 3'b101};
    logic [31:0] addr [8] = '{32'h202, 32'h202, 32'h202, 32'h200, 32'h203, 32'h200, 32'h200,
                              32'h202};
    logic [31:0] rd   [8] = '{32'h12F03456, 32'h12F03456, 32'h12F03456, 32'h12F03456,
                              32'h12F03456, 32'h12F03456, 32'h8001FF7F, 32'h8001FF7F};
    logic [31:0] xr   [8] = '{32'hFFFFFFF0, 32'h000000F0, 32'h000012F0, 32'h00003456,
                              32'h00000012, 32'h12F03456, 32'hFFFFFF7F, 32'h00008001};
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_rdata = rd[i];
      push_exp(xr[i], 1'b0, 1'b0);
      drive_req(1'b0, f3[i], addr[i], 32'hFFFFFFFF);
      checks++;
      if ({mem_valid, mem_we, mem_addr, mem_wstrb} !== {1'b1, 1'b0, 32'h200, 4'b0000}) begin
        errors++;
        $display("FAIL load_bus[%0d]: got v=%b we=%b a=%h s=%b want 1 0 00000200 0000",
                 i, mem_valid, mem_we, mem_addr, mem_wstrb);
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1) begin
        errors++;
        $display("FAIL load_latency[%0d]: got resp_valid=%b want 1", i, resp_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_misaligned();
    logic        we   [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3   [9] = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b001, 3'b011, 3'b110,
                              3'b111, 3'b100};
    logic [31:0] addr [9] = '{32'h301, 32'h301, 32'h302, 32'h102, 32'h101, 32'h100, 32'h100,
                              32'h100, 32'h100};
    mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_exp(32'h0, 1'b1, 1'b0);
      drive_req(we[i], f3[i], addr[i], 32'h55AA55AA);
      checks++;
      if ({resp_valid, mem_valid} !== 2'b10) begin
        errors++;
        $display("FAIL mis_resp[%0d]: got resp_valid=%b mem_valid=%b want 1 0",
                 i, resp_valid, mem_valid);
      end
      @(negedge clk);
      checks++;
      if ({req_ready, mem_valid, resp_valid} !== 3'b100) begin
        errors++;
        $display("FAIL mis_idle[%0d]: got rdy=%b v=%b rv=%b want 1 0 0",
                 i, req_ready, mem_valid, resp_valid);
      end
    end
  endtask

  task automatic test_timeout();
    int  idx = 0;
    bit  bus_ok = 1'b1;
    mem_ready = 1'b0;
    push_exp(32'h0, 1'b0, 1'b1);
    drive_req(1'b0, 3'b010, 32'h400, 32'h0);
    while (resp_valid !== 1'b1 && idx < 20) begin
      if (mem_valid !== 1'b1) bus_ok = 1'b0;
      @(negedge clk);
      idx++;
    end
    checks++;
    if (idx != TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: got resp after %0d BUS cycles want %0d", idx, TO + 1);
    end
    checks++;
    if (!bus_ok || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_bus: got held_ok=%b mem_valid_at_resp=%b want 1 0",
               bus_ok, mem_valid);
    end
    @(negedge clk);
    checks++;
    if ({mem_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_after: got v=%b rdy=%b want 0 1", mem_valid, req_ready);
    end
  endtask

  // ready_idx counts BUS cycles from 0; with ready_idx == TO the count is at
  // its limit in the same cycle mem_ready rises.
  task automatic test_late_ready(input int ready_idx);
    int idx = 0;
    bit early = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'hCAFEF00D;
    push_exp(32'hCAFEF00D, 1'b0, 1'b0);
    drive_req(1'b0, 3'b010, 32'h500, 32'h0);
    while (idx < ready_idx) begin
      if (resp_valid === 1'b1 || mem_valid !== 1'b1) early = 1'b1;
      @(negedge clk);
      idx++;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++;
    if (early || resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL late_ready[%0d]: got early=%b resp_valid=%b want 0 1",
               ready_idx, early, resp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_bus();
    mem_ready = 1'b0;
    drive_req(1'b0, 3'b010, 32'h600, 32'h0);
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_bus_pre: got mem_valid=%b want 1", mem_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({mem_valid, req_ready, resp_valid} !== 3'b010) begin
      errors++;
      $display("FAIL rst_bus_drop: got v=%b rdy=%b rv=%b want 0 1 0",
               mem_valid, req_ready, resp_valid);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h0BADCAFE;
    push_exp(32'h0BADCAFE, 1'b0, 1'b0);
    drive_req(1'b0, 3'b010, 32'h604, 32'h0);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_bus_next: got resp_valid=%b want 1", resp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b0;
    push_exp(32'h11223344, 1'b0, 1'b0);
    drive_req(1'b0, 3'b010, 32'h700, 32'h0);
    req_valid = 1'b1;
    req_addr  = 32'h7F0;
    req_we    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy, req_ready, mem_addr, mem_we} !== {2'b10, 32'h700, 1'b0}) begin
        errors++;
        $display("FAIL busy_ignore[%0d]: got busy=%b rdy=%b a=%h we=%b want 1 0 00000700 0",
                 i, busy, req_ready, mem_addr, mem_we);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h11223344;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL busy_resp: got resp_valid=%b want 1", resp_valid);
    end
    @(negedge clk);
  endtask

  initial begin
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    reset      = 1'b1;
    @(negedge clk);
    test_reset();
    test_stores();
    test_loads();
    test_misaligned();
    test_timeout();
    test_late_ready(3);
    test_late_ready(TO);
    test_reset_mid_bus();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL resp_missing: got %0d unanswered requests want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit in the execute→memory boundary of the RISC-V core, directly downstream of the ALU. It takes the ALU result as the effective address, forms byte strobes and lane-aligned write data for stores, and runs a single outstanding valid/ready transaction on the data bus. It then returns sign- or zero-extended load data to writeback, or flags a misaligned access or bus timeout.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles waiting for mem_ready before a timeout response; 0 disables the timeout.
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  memory op request from execute
- req_ready  output  1  LSU can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I load/store funct3
- req_addr  input  32  effective address (ALU result)
- req_wdata  input  32  store data (rs2, unaligned)
- mem_valid  output  1  bus request
- mem_ready  input  1  bus accept/complete
- mem_we  output  1  bus write
- mem_addr  output  32  word-aligned address (req_addr & ~3)
- mem_wstrb  output  4  byte strobes (0000 on loads)
- mem_wdata  output  32  lane-shifted store data
- mem_rdata  input  32  read data, valid when mem_valid && mem_ready
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data (0 for stores and errors)
- resp_misaligned  output  1  completion is an address-misaligned exception
- resp_timeout  output  1  completion is a bus timeout
- busy  output  1  state != IDLE

## Operation
- States: IDLE, BUS, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* fields.
  - Misaligned (halfword with addr[0]=1, word with addr[1:0]≠0) or illegal funct3 (011, 110, 111, and stores with funct3[2]=1): go to RESP with resp_misaligned=1; no bus cycle.
  - Otherwise go to BUS.
- BUS: mem_valid=1 and bus outputs held stable.
  - mem_ready=1: capture mem_rdata and go to RESP.
  - Timeout counter reaches TIMEOUT_CYCLES first: go to RESP with resp_timeout=1, dropping mem_valid.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Stores:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111; wdata passed through.
- Loads: select byte or halfword by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- resp_misaligned and resp_timeout are mutually exclusive. Both are 0 on normal completion.
- Reset: state=IDLE, timeout counter=0. All outputs 0 except req_ready=1. Bus outputs are 0 whenever mem_valid=0.
- Reset mid-BUS drops mem_valid on the next edge with no response. The bus slave must tolerate an abandoned request.

## Timing
- Request accepted at edge N. BUS, with mem_valid high, from cycle N+1.
- mem_ready sampled high at edge M gives resp_valid in cycle M+1.
- Zero-wait bus (mem_ready already high): accept → resp_valid in 2 cycles. Next req_ready is at cycle M+2.
- Misaligned or illegal: resp_valid in cycle N+1; mem_valid never asserts.
- Timeout counter:
  - Clears on entering BUS and increments each BUS cycle with mem_ready=0.
  - Timeout fires when the count equals TIMEOUT_CYCLES, giving resp_valid TIMEOUT_CYCLES+1 cycles after BUS entry.
  - mem_ready=1 in the same cycle the count reaches the limit wins: normal completion.
- req_valid held during busy is ignored, not queued. Upstream stalls on busy.

## Structure
- Shared constants package additions:
  - funct3 codes: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - lsu_state_t enum {IDLE, BUS, RESP}.
- Sub-module lsu_align (combinational): funct3 + addr[1:0] + data → wstrb, shifted wdata, extended rdata, misaligned flag. The LSU top holds the FSM, request latches and timeout counter.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, mem_ready tied high → mem_addr=0x100, wstrb=1111, resp_valid 2 cycles after accept, resp_rdata=0.
- SB addr=0x103, wdata=0x000000A5 → mem_addr=0x100, wstrb=1000, mem_wdata=0xA5A5A5A5.
- LB addr=0x202, mem_rdata=0x12F03456 → resp_rdata=0xFFFFFFF0; LBU same → 0x000000F0; LH addr=0x202 → 0x000012F0.
- LW addr=0x301 → resp_misaligned=1 in cycle N+1, mem_valid never high; LH addr=0x301 likewise.
- TIMEOUT_CYCLES=4, mem_ready held 0 → resp_timeout=1 on the 5th cycle after BUS entry, mem_valid low afterwards; separately, mem_ready=1 on the 4th BUS cycle → normal completion.
- Reset asserted during BUS with mem_ready=0 → next cycle mem_valid=0, req_ready=1, no resp_valid; a following LW completes normally.
